// File: rtl/dec_lut_decoder_param_clk.sv
// Table-driven decoder: finds the table index whose stored code word
// matches a query word, scanning LANES entries per clock.
// Optional feature macro DEC_LUT_EARLY_EXIT_EN: when defined, the scan
// stops after the group holding the first match. Otherwise the latency
// is fixed at DEPTH/LANES+1 cycles. Both builds give the same found/N result.
module dec_lut_decoder_param_clk #(
  parameter int W_BITS = 20,
  parameter int N_BITS = 9,
  parameter int DEPTH  = 512,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lut_we,
  input  logic [N_BITS-1:0] lut_waddr,
  input  logic [W_BITS-1:0] lut_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_BITS-1:0] W,
  output logic              done,
  output logic              found,
  output logic [N_BITS-1:0] N
);

  localparam int GROUPS = DEPTH / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0]   LAST_GRP  = GW'(GROUPS - 1);
  localparam logic [N_BITS:0] DEPTH_LIM = (N_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [GW-1:0]       grp_r;
  logic [W_BITS-1:0]   w_r;
  logic                acc_found_r;
  logic [N_BITS-1:0]   acc_idx_r;
  logic [W_BITS-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]    vld_r;

  logic [N_BITS-1:0]   base_s;
  logic [N_BITS-1:0]   lane_idx_s [LANES];
  logic [LANES-1:0]    match_s;
  logic                hit_s;
  logic [N_BITS-1:0]   hit_idx_s;
  logic                wr_ok_s;
  logic                last_s;
  logic                leave_s;
  logic                fin_found_s;
  logic [N_BITS-1:0]   fin_idx_s;

  // Table writes are only taken while idle and only for in-range indices.
  assign wr_ok_s = lut_we && (state_r == IDLE) && ({1'b0, lut_waddr} < DEPTH_LIM);

  // Compare the current group; the lowest matching lane wins.
  always_comb begin
    base_s    = N_BITS'(grp_r) * N_BITS'(LANES);
    match_s   = {LANES{1'b0}};
    hit_s     = 1'b0;
    hit_idx_s = {N_BITS{1'b1}};
    for (int l = LANES - 1; l >= 0; l--) begin
      lane_idx_s[l] = base_s + N_BITS'(l);
      match_s[l]    = vld_r[lane_idx_s[l]] && (mem_r[lane_idx_s[l]] == w_r);
      if (match_s[l]) begin
        hit_s     = 1'b1;
        hit_idx_s = lane_idx_s[l];
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Decide when the scan ends and what result it produces.
  always_comb begin
    last_s = (grp_r == LAST_GRP);
`ifdef DEC_LUT_EARLY_EXIT_EN
    leave_s = last_s || hit_s;
`else
    leave_s = last_s;
`endif
    fin_found_s = acc_found_r || hit_s;
    if (acc_found_r) begin
      fin_idx_s = acc_idx_r;
    end else begin
      fin_idx_s = hit_idx_s;
    end
  end

  // Stored code words; contents need no reset because valid bits gate them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[lut_waddr] <= lut_wdata;
    end
  end

  // Entry valid bits, cleared by reset and set by accepted writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= {DEPTH{1'b0}};
    end else if (wr_ok_s) begin
      vld_r[lut_waddr] <= 1'b1;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      done        <= 1'b0;
      found       <= 1'b0;
      N           <= {N_BITS{1'b0}};
      grp_r       <= {GW{1'b0}};
      w_r         <= {W_BITS{1'b0}};
      acc_found_r <= 1'b0;
      acc_idx_r   <= {N_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (in_valid && in_ready) begin
            w_r         <= W;
            grp_r       <= {GW{1'b0}};
            acc_found_r <= 1'b0;
            in_ready    <= 1'b0;
            state_r     <= SCAN;
          end
        end
        SCAN: begin
          if (hit_s && !acc_found_r) begin
            acc_found_r <= 1'b1;
            acc_idx_r   <= hit_idx_s;
          end
          if (leave_s) begin
            done    <= 1'b1;
            found   <= fin_found_s;
            N       <= fin_idx_s;
            state_r <= DONE;
          end else begin
            grp_r <= grp_r + GW'(1'b1);
          end
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_lut_decoder_param_clk.sv
// Bench for dec_lut_decoder_param_clk: one LANES=1 and one LANES=4 instance,
// random and directed queries checked against an array-based table model.
module tb_dec_lut_decoder_param_clk;

  logic clk;
  logic rst;
  logic a_we, a_valid, a_ready, a_done, a_found;
  logic [8:0] a_waddr, a_n;
  logic [19:0] a_wdata, a_w;
  logic b_we, b_valid, b_ready, b_done, b_found;
  logic [8:0] b_waddr, b_n;
  logic [19:0] b_wdata, b_w;

  int nvec = 0;
  int nerr = 0;

  logic [19:0] m_word [2][512];
  bit          m_vld  [2][512];

  dec_lut_decoder_param_clk #(.W_BITS(20), .N_BITS(9), .DEPTH(512), .LANES(1)) dut_a (
    .clk(clk), .rst(rst), .lut_we(a_we), .lut_waddr(a_waddr), .lut_wdata(a_wdata),
    .in_valid(a_valid), .in_ready(a_ready), .W(a_w), .done(a_done), .found(a_found), .N(a_n));

  dec_lut_decoder_param_clk #(.W_BITS(20), .N_BITS(9), .DEPTH(512), .LANES(4)) dut_b (
    .clk(clk), .rst(rst), .lut_we(b_we), .lut_waddr(b_waddr), .lut_wdata(b_wdata),
    .in_valid(b_valid), .in_ready(b_ready), .W(b_w), .done(b_done), .found(b_found), .N(b_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? a_done : b_done;
  endfunction
  function automatic logic found_of(input int sel);
    return (sel == 0) ? a_found : b_found;
  endfunction
  function automatic logic [8:0] n_of(input int sel);
    return (sel == 0) ? a_n : b_n;
  endfunction

  // Reference: first valid entry holding the word, searching from index 0.
  function automatic void model_find(input int sel, input logic [19:0] w,
                                     output bit hit, output int idx);
    hit = 1'b0;
    idx = 511;
    for (int i = 0; i < 512; i++) begin
      if (!hit && m_vld[sel][i] && m_word[sel][i] == w) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endfunction

  function automatic int exp_lat(input int sel, input bit hit, input int idx);
    int lanes;
    lanes = (sel == 0) ? 1 : 4;
`ifdef DEC_LUT_EARLY_EXIT_EN
    if (hit) return idx / lanes + 2;
`endif
    return 512 / lanes + 1;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 512; i++) m_vld[s][i] = 1'b0;
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [19:0] w,
                          input logic we, input logic [8:0] wa, input logic [19:0] wd);
    if (sel == 0) begin
      a_valid = v; a_w = w; a_we = we; a_waddr = wa; a_wdata = wd;
    end else begin
      b_valid = v; b_w = w; b_we = we; b_waddr = wa; b_wdata = wd;
    end
  endtask

  task automatic lut_write(input int sel, input logic [8:0] a, input logic [19:0] d);
    drive_in(sel, 1'b0, 20'd0, 1'b1, a, d);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, 20'd0, 1'b0, 9'd0, 20'd0);
    m_word[sel][a] = d;
    m_vld[sel][a]  = 1'b1;
  endtask

  // Issue one query; cyc is the cycle (acceptance = 0) in which done is seen,
  // or -1 on timeout. d_next is done one cycle later.
  task automatic run_query(input int sel, input logic [19:0] w, input logic we,
                           input logic [8:0] wa, input logic [19:0] wd, input int mid_cyc,
                           output int cyc, output logic f, output logic [8:0] n,
                           output logic d_next);
    int t;
    t = 0;
    while (ready_of(sel) !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    drive_in(sel, 1'b1, w, we, wa, wd);
    @(posedge clk); #1;
    cyc = 1;
    while (done_of(sel) !== 1'b1 && cyc < 700) begin
      drive_in(sel, 1'b0, 20'($urandom), (cyc == mid_cyc) ? 1'b1 : 1'b0, wa, wd);
      @(posedge clk); #1;
      cyc++;
    end
    drive_in(sel, 1'b0, 20'd0, 1'b0, 9'd0, 20'd0);
    if (cyc >= 700) cyc = -1;
    f = found_of(sel);
    n = n_of(sel);
    @(posedge clk); #1;
    d_next = done_of(sel);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({a_done, a_found, a_n} !== {1'b0, 1'b0, 9'h000}) begin
      nerr++; $display("FAIL reset_a done/found/N got %b/%b/%h want 0/0/000", a_done, a_found, a_n);
    end
    nvec++;
    if ({b_done, b_found, b_n} !== {1'b0, 1'b0, 9'h000}) begin
      nerr++; $display("FAIL reset_b done/found/N got %b/%b/%h want 0/0/000", b_done, b_found, b_n);
    end
    rst = 1'b0;
    nvec++;
    if ({a_ready, b_ready} !== 2'b11) begin
      nerr++; $display("FAIL reset_ready got %b%b want 11", a_ready, b_ready);
    end
  endtask

  task automatic test_basic();
    int cyc; logic f, d; logic [8:0] n;
    lut_write(0, 9'd255, 20'd12345);
    run_query(0, 20'd12345, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
    nvec++;
    if (cyc !== exp_lat(0, 1'b1, 255)) begin
      nerr++; $display("FAIL basic_latency got %0d want %0d", cyc, exp_lat(0, 1'b1, 255));
    end
    nvec++;
    if ({f, n} !== {1'b1, 9'd255}) begin
      nerr++; $display("FAIL basic_result found/N got %b/%0d want 1/255", f, n);
    end
    nvec++;
    if (d !== 1'b0) begin
      nerr++; $display("FAIL basic_done_width done after strobe got %b want 0", d);
    end
  endtask

  task automatic test_miss();
    int cyc; logic f, d; logic [8:0] n;
    run_query(0, 20'd777, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
    nvec++;
    if (cyc !== 513) begin
      nerr++; $display("FAIL miss_latency got %0d want 513", cyc);
    end
    nvec++;
    if ({f, n} !== {1'b0, 9'h1FF}) begin
      nerr++; $display("FAIL miss_result found/N got %b/%h want 0/1ff", f, n);
    end
  endtask

  task automatic test_lowest();
    int cyc; logic f, d; logic [8:0] n;
    lut_write(1, 9'd300, 20'd42);
    lut_write(1, 9'd10, 20'd42);
    run_query(1, 20'd42, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
    nvec++;
`ifdef DEC_LUT_EARLY_EXIT_EN
    if (cyc !== 4) begin
      nerr++; $display("FAIL lowest_latency got %0d want 4", cyc);
    end
`else
    if (cyc !== 129) begin
      nerr++; $display("FAIL lowest_latency got %0d want 129", cyc);
    end
`endif
    nvec++;
    if ({f, n} !== {1'b1, 9'd10}) begin
      nerr++; $display("FAIL lowest_result found/N got %b/%0d want 1/10", f, n);
    end
    nvec++;
    if (d !== 1'b0) begin
      nerr++; $display("FAIL lowest_done_width got %b want 0", d);
    end
  endtask

  task automatic test_scan_write();
    int cyc, idx; logic f, d; logic [8:0] n; bit hit;
    logic [19:0] word;
    word = 20'd555;
    model_find(0, word, hit, idx);
    while (hit) begin
      word = word + 20'd1;
      model_find(0, word, hit, idx);
    end
    // the write attempted mid-scan must be dropped, so the model is untouched
    run_query(0, 20'd12345, 1'b0, 9'd5, word, 3, cyc, f, n, d);
    nvec++;
    if ({f, n} !== {1'b1, 9'd255}) begin
      nerr++; $display("FAIL scan_write_query found/N got %b/%0d want 1/255", f, n);
    end
    run_query(0, word, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
    nvec++;
    if ({f, n} !== {1'b0, 9'h1FF}) begin
      nerr++; $display("FAIL scan_write_dropped found/N got %b/%h want 0/1ff", f, n);
    end
  endtask

  task automatic test_random();
    int cyc, idx, sel, pick, elat; logic f, d; logic [8:0] n; bit hit;
    logic [19:0] w;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 1);
      for (int k = 0; k < 4; k++)
        lut_write(sel, 9'($urandom_range(0, 511)), 20'($urandom_range(0, 31)));
      w = 20'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, 511);
        for (int i = 0; i < 512; i++)
          if (m_vld[sel][(pick + i) % 512]) begin
            w = m_word[sel][(pick + i) % 512];
            break;
          end
      end
      model_find(sel, w, hit, idx);
      elat = exp_lat(sel, hit, idx);
      run_query(sel, w, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
      nvec++;
      if (cyc !== elat || f !== hit || n !== 9'(idx) || d !== 1'b0) begin
        nerr++;
        $display("FAIL random_query sel=%0d w=%0d got cyc=%0d found=%b N=%0d dnext=%b want cyc=%0d found=%b N=%0d dnext=0",
                 sel, w, cyc, f, n, d, elat, hit, idx);
      end
    end
  endtask

  task automatic test_abort_reset();
    int cyc, cnt; logic f, d; logic [8:0] n;
    lut_write(0, 9'd20, 20'd4321);
    run_query(0, 20'd4321, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
    nvec++;
    if (f !== 1'b1) begin
      nerr++; $display("FAIL abort_prequery found got %b want 1", f);
    end
    drive_in(0, 1'b1, 20'd4321, 1'b0, 9'd0, 20'd0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 20'd0, 1'b0, 9'd0, 20'd0);
    cyc = 1;
    while (cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({a_done, a_found, a_n} !== {1'b0, 1'b0, 9'h000}) begin
      nerr++; $display("FAIL abort_reset_outputs done/found/N got %b/%b/%h want 0/0/000", a_done, a_found, a_n);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    nvec++;
    if (a_ready !== 1'b1) begin
      nerr++; $display("FAIL abort_ready got %b want 1", a_ready);
    end
    cnt = 0;
    repeat (600) begin
      if (a_done === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    nvec++;
    if (cnt !== 0) begin
      nerr++; $display("FAIL abort_no_done done strobes got %0d want 0", cnt);
    end
    run_query(0, 20'd4321, 1'b0, 9'd0, 20'd0, 0, cyc, f, n, d);
    nvec++;
    if ({f, n} !== {1'b0, 9'h1FF}) begin
      nerr++; $display("FAIL abort_entries_invalid found/N got %b/%h want 0/1ff", f, n);
    end
  endtask

  task automatic test_same_cycle();
    int cyc; logic f, d; logic [8:0] n;
    m_word[0][0] = 20'd9;
    m_vld[0][0]  = 1'b1;
    run_query(0, 20'd9, 1'b1, 9'd0, 20'd9, 0, cyc, f, n, d);
    nvec++;
    if ({f, n} !== {1'b1, 9'd0}) begin
      nerr++; $display("FAIL same_cycle_result found/N got %b/%0d want 1/0", f, n);
    end
    nvec++;
    if (cyc !== exp_lat(0, 1'b1, 0)) begin
      nerr++; $display("FAIL same_cycle_latency got %0d want %0d", cyc, exp_lat(0, 1'b1, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_in(0, 1'b0, 20'd0, 1'b0, 9'd0, 20'd0);
    drive_in(1, 1'b0, 20'd0, 1'b0, 9'd0, 20'd0);
    model_clear();
    test_reset();
    test_basic();
    test_miss();
    test_lowest();
    test_scan_write();
    test_random();
    test_abort_reset();
    test_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
